scope_sample_buffer: RTL and testbench

- Double-buffered capture store between the ADC timing stage and the VGA generator.
- Captures one triggered frame of 8-bit ADC samples into a back bank while the front bank is read out by pixel column.
- Banks swap only during vertical blank, so the displayed waveform never tears.

---
 rtl/scope_pkg.sv | 15 +
 rtl/scope_bank_ram.sv | 41 ++++
 rtl/scope_sample_buffer.sv | 139 +++++++++++++
 tb/tb_scope_sample_buffer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/scope_pkg.sv
// Shared types and sizes for the oscilloscope sample buffer.
// Used by scope_sample_buffer and scope_bank_ram.
package scope_pkg;

    localparam int SCOPE_DEPTH = 640;
    localparam int SCOPE_AW    = 10;
    localparam int SAMPLE_W    = 8;

    typedef enum logic [1:0] {
        ARM     = 2'd0,
        CAPTURE = 2'd1,
        FULL    = 2'd2
    } scopeState_e;

endpackage

// File: rtl/scope_bank_ram.sv
// Two-bank sample store: one write port into the back bank, one registered read port
// from the front bank, both packed into a single 2*DEPTH array.
module scope_bank_ram
    import scope_pkg::*;
#(
    parameter int DEPTH = SCOPE_DEPTH,
    parameter int AW    = SCOPE_AW
) (
    input  logic                Clk,
    input  logic                frontSel,
    input  logic                wrEn,
    input  logic [AW-1:0]       wrAddr,
    input  logic [SAMPLE_W-1:0] wrData,
    input  logic [AW-1:0]       rdAddr,
    output logic [SAMPLE_W-1:0] rdData
);

    localparam int IW = $clog2(2 * DEPTH);

    logic [SAMPLE_W-1:0] mem [2*DEPTH];
    logic [IW-1:0]       wrIdx;
    logic [IW-1:0]       rdIdx;

    // Bank 1 sits above bank 0; out-of-range columns fold to 0 and are masked by the caller.
    function automatic logic [IW-1:0] bankIdx(input logic bank, input logic [AW-1:0] addr);
        logic [IW-1:0] a;
        a = (addr < AW'(DEPTH)) ? IW'(addr) : '0;
        return bank ? (IW'(DEPTH) + a) : a;
    endfunction

    assign wrIdx = bankIdx(~frontSel, wrAddr);
    assign rdIdx = bankIdx(frontSel, rdAddr);

    always_ff @(posedge Clk) begin
        if (wrEn) begin
            mem[wrIdx] <= wrData;
        end
        rdData <= mem[rdIdx];
    end

endmodule

// File: rtl/scope_sample_buffer.sv
// Double-buffered ADC frame capture for the VGA scope; banks swap only at frameStart (vblank).
// SCOPE_TRIGGER_EN: defined = rising-edge level trigger with timeout, undefined = free-running capture.
module scope_sample_buffer
    import scope_pkg::*;
#(
    parameter int                  DEPTH        = SCOPE_DEPTH,
    parameter int                  AW           = SCOPE_AW,
    parameter logic [SAMPLE_W-1:0] TRIG_LEVEL   = 8'd128,
    parameter int                  TRIG_TIMEOUT = 4096
) (
    input  logic                Clk,
    input  logic                bufRst,
    input  logic                sampleValid,
    input  logic [SAMPLE_W-1:0] sampleData,
    input  logic                frameStart,
    input  logic [AW-1:0]       rdAddr,
    output logic [SAMPLE_W-1:0] curveData,
    output logic                captureBusy,
    output logic                bufSwapped,
    output logic [7:0]          dropCount
);

    scopeState_e         state;
    logic [AW-1:0]       wrAddr;
    logic [AW-1:0]       ramWrAddr;
    logic                frontSel;
    logic                frontValid;
    logic                armStart;
    logic                wrEn;
    logic                lastWrite;
    logic                swapNow;
    logic                rdOk_p1;
    logic [SAMPLE_W-1:0] ramData_p1;

    function automatic logic [7:0] satInc(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

`ifdef SCOPE_TRIGGER_EN
    localparam int TW = $clog2(TRIG_TIMEOUT);

    logic [TW-1:0]       toCnt;
    logic [SAMPLE_W-1:0] prevSample;
    logic                trigHit;
    logic                toHit;

    assign trigHit  = (prevSample < TRIG_LEVEL) && (sampleData >= TRIG_LEVEL);
    assign toHit    = (toCnt == TW'(TRIG_TIMEOUT - 1));
    assign armStart = (state == ARM) && sampleValid && (trigHit || toHit);

    always_ff @(posedge Clk or posedge bufRst) begin
        if (bufRst) begin
            toCnt      <= '0;
            prevSample <= '0;
        end else if (swapNow) begin
            toCnt <= '0;
        end else if ((state == ARM) && sampleValid) begin
            prevSample <= sampleData;
            toCnt      <= toCnt + TW'(1);
        end
    end
`else
    logic unusedTrigCfg;

    assign armStart      = (state == ARM) && sampleValid;
    assign unusedTrigCfg = ^{TRIG_LEVEL, TRIG_TIMEOUT};
`endif

    assign lastWrite   = (state == CAPTURE) && sampleValid && (wrAddr == AW'(DEPTH - 1));
    assign swapNow     = (state == FULL) && frameStart;
    assign wrEn        = armStart || ((state == CAPTURE) && sampleValid);
    assign ramWrAddr   = (state == ARM) ? '0 : wrAddr;
    assign captureBusy = (state == ARM) || (state == CAPTURE);

    always_ff @(posedge Clk or posedge bufRst) begin
        if (bufRst) begin
            state      <= ARM;
            wrAddr     <= '0;
            frontSel   <= 1'b0;
            frontValid <= 1'b0;
            dropCount  <= '0;
            bufSwapped <= 1'b0;
        end else begin
            bufSwapped <= swapNow;
            case (state)
                ARM: begin
                    if (armStart) begin
                        state  <= CAPTURE;
                        wrAddr <= AW'(1);
                    end
                end
                CAPTURE: begin
                    if (lastWrite) begin
                        state  <= FULL;
                        wrAddr <= '0;
                    end else if (sampleValid) begin
                        wrAddr <= wrAddr + AW'(1);
                    end
                end
                FULL: begin
                    if (sampleValid) begin
                        dropCount <= satInc(dropCount);
                    end
                    if (frameStart) begin
                        frontSel   <= ~frontSel;
                        frontValid <= 1'b1;
                        state      <= ARM;
                    end
                end
                default: state <= ARM;
            endcase
        end
    end

    scope_bank_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) uBankRam (
        .Clk      (Clk),
        .frontSel (frontSel),
        .wrEn     (wrEn),
        .wrAddr   (ramWrAddr),
        .wrData   (sampleData),
        .rdAddr   (rdAddr),
        .rdData   (ramData_p1)
    );

    // Read stage p1: the mask travels with the RAM read so blanked columns come out as 0.
    always_ff @(posedge Clk or posedge bufRst) begin
        if (bufRst) begin
            rdOk_p1 <= 1'b0;
        end else begin
            rdOk_p1 <= frontValid && (rdAddr < AW'(DEPTH));
        end
    end

    assign curveData = rdOk_p1 ? ramData_p1 : '0;

endmodule

// File: tb/tb_scope_sample_buffer.sv
// Directed testbench for scope_sample_buffer; expectations adapt to SCOPE_TRIGGER_EN.
module tb_scope_sample_buffer;

`ifdef SCOPE_TRIGGER_EN
    localparam bit TRIG_MODE = 1'b1;
`else
    localparam bit TRIG_MODE = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       bufRst = 1'b1;
    logic       sampleValid = 1'b0;
    logic [7:0] sampleData = 8'd0;
    logic       frameStart = 1'b0;
    logic [9:0] rdAddr = 10'd0;
    logic [7:0] curveData;
    logic       captureBusy;
    logic       bufSwapped;
    logic [7:0] dropCount;

    int         nChecks = 0;
    int         nFails = 0;
    logic [7:0] rd;
    logic [7:0] exp8;

    scope_sample_buffer dut (
        .Clk         (Clk),
        .bufRst      (bufRst),
        .sampleValid (sampleValid),
        .sampleData  (sampleData),
        .frameStart  (frameStart),
        .rdAddr      (rdAddr),
        .curveData   (curveData),
        .captureBusy (captureBusy),
        .bufSwapped  (bufSwapped),
        .dropCount   (dropCount)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic sendSample(input logic [7:0] v, input int gap);
        sampleValid = 1'b1;
        sampleData  = v;
        tick();
        sampleValid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic pulseFrame();
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
    endtask

    task automatic readAt(input int a, output logic [7:0] d);
        rdAddr = 10'(a);
        tick();
        d = curveData;
    endtask

    function automatic logic [7:0] seqVal(input int j);
        if (j == 0) return 8'd100;
        if (j == 1) return 8'd120;
        return 8'(128 + j);
    endfunction

    task automatic test_reset();
        repeat (2) tick();
        nChecks++; if (curveData !== 8'd0) begin nFails++; $display("FAIL reset_curveData: got %0d want 0", curveData); end
        nChecks++; if (captureBusy !== 1'b1) begin nFails++; $display("FAIL reset_busy: got %0b want 1", captureBusy); end
        nChecks++; if (bufSwapped !== 1'b0) begin nFails++; $display("FAIL reset_swapped: got %0b want 0", bufSwapped); end
        nChecks++; if (dropCount !== 8'd0) begin nFails++; $display("FAIL reset_drop: got %0d want 0", dropCount); end
        bufRst = 1'b0;
        tick();
        for (int a = 0; a < 640; a++) begin
            readAt(a, rd);
            nChecks++; if (rd !== 8'd0) begin nFails++; $display("FAIL reset_read[%0d]: got %0d want 0", a, rd); end
        end
        nChecks++; if (captureBusy !== 1'b1) begin nFails++; $display("FAIL reset_busy_after: got %0b want 1", captureBusy); end
    endtask

    task automatic test_trigger();
        for (int j = 0; j < 642; j++) sendSample(seqVal(j), 3);
        nChecks++; if (captureBusy !== 1'b0) begin nFails++; $display("FAIL trig_full: busy got %0b want 0", captureBusy); end
        exp8 = TRIG_MODE ? 8'd0 : 8'd2;
        nChecks++; if (dropCount !== exp8) begin nFails++; $display("FAIL trig_drop: got %0d want %0d", dropCount, exp8); end
        readAt(0, rd);
        nChecks++; if (rd !== 8'd0) begin nFails++; $display("FAIL trig_preswap_read: got %0d want 0", rd); end
        nChecks++; if (bufSwapped !== 1'b0) begin nFails++; $display("FAIL trig_preswap_pulse: got %0b want 0", bufSwapped); end
        pulseFrame();
        nChecks++; if (bufSwapped !== 1'b1) begin nFails++; $display("FAIL trig_swap_pulse: got %0b want 1", bufSwapped); end
        nChecks++; if (captureBusy !== 1'b1) begin nFails++; $display("FAIL trig_rearm: busy got %0b want 1", captureBusy); end
        tick();
        nChecks++; if (bufSwapped !== 1'b0) begin nFails++; $display("FAIL trig_swap_pulse_end: got %0b want 0", bufSwapped); end
        readAt(0, rd);
        exp8 = TRIG_MODE ? 8'd130 : 8'd100;
        nChecks++; if (rd !== exp8) begin nFails++; $display("FAIL trig_read0: got %0d want %0d", rd, exp8); end
        readAt(1, rd);
        exp8 = TRIG_MODE ? 8'd131 : 8'd120;
        nChecks++; if (rd !== exp8) begin nFails++; $display("FAIL trig_read1: got %0d want %0d", rd, exp8); end
        readAt(639, rd);
        exp8 = TRIG_MODE ? 8'd1 : 8'd255;
        nChecks++; if (rd !== exp8) begin nFails++; $display("FAIL trig_read639: got %0d want %0d", rd, exp8); end
    endtask

    task automatic test_timeout();
        int n;
        n = TRIG_MODE ? 4735 : 640;
        for (int i = 0; i < n - 1; i++) sendSample(8'd50, 0);
        nChecks++; if (captureBusy !== 1'b1) begin nFails++; $display("FAIL timeout_early: busy got %0b want 1", captureBusy); end
        sendSample(8'd50, 0);
        nChecks++; if (captureBusy !== 1'b0) begin nFails++; $display("FAIL timeout_full: busy got %0b want 0", captureBusy); end
        pulseFrame();
        nChecks++; if (bufSwapped !== 1'b1) begin nFails++; $display("FAIL timeout_swap: got %0b want 1", bufSwapped); end
        for (int a = 0; a < 640; a++) begin
            readAt(a, rd);
            nChecks++; if (rd !== 8'd50) begin nFails++; $display("FAIL timeout_read[%0d]: got %0d want 50", a, rd); end
        end
        exp8 = TRIG_MODE ? 8'd0 : 8'd2;
        nChecks++; if (dropCount !== exp8) begin nFails++; $display("FAIL timeout_drop: got %0d want %0d", dropCount, exp8); end
    endtask

    task automatic test_drop_saturate();
        for (int i = 0; i < 640; i++) sendSample(8'(200 + i), 0);
        nChecks++; if (captureBusy !== 1'b0) begin nFails++; $display("FAIL drop_full: busy got %0b want 0", captureBusy); end
        readAt(0, rd);
        nChecks++; if (rd !== 8'd50) begin nFails++; $display("FAIL drop_front0: got %0d want 50", rd); end
        readAt(639, rd);
        nChecks++; if (rd !== 8'd50) begin nFails++; $display("FAIL drop_front639: got %0d want 50", rd); end
        for (int i = 0; i < 300; i++) sendSample(8'(i), 0);
        nChecks++; if (dropCount !== 8'd255) begin nFails++; $display("FAIL drop_sat: got %0d want 255", dropCount); end
        readAt(5, rd);
        nChecks++; if (rd !== 8'd50) begin nFails++; $display("FAIL drop_front5: got %0d want 50", rd); end
        pulseFrame();
        nChecks++; if (bufSwapped !== 1'b1) begin nFails++; $display("FAIL drop_swap: got %0b want 1", bufSwapped); end
        readAt(0, rd);
        nChecks++; if (rd !== 8'd200) begin nFails++; $display("FAIL drop_read0: got %0d want 200", rd); end
        readAt(100, rd);
        nChecks++; if (rd !== 8'd44) begin nFails++; $display("FAIL drop_read100: got %0d want 44", rd); end
    endtask

    task automatic test_same_cycle();
        pulseFrame();
        nChecks++; if (bufSwapped !== 1'b0) begin nFails++; $display("FAIL same_arm_noswap: got %0b want 0", bufSwapped); end
        if (TRIG_MODE) sendSample(8'd10, 0);
        for (int i = 0; i < 639; i++) begin
            sendSample(8'(150 + i), 1);
            if (i == 300) begin
                pulseFrame();
                nChecks++; if (bufSwapped !== 1'b0) begin nFails++; $display("FAIL same_capture_noswap: got %0b want 0", bufSwapped); end
            end
        end
        sampleValid = 1'b1;
        sampleData  = 8'(150 + 639);
        frameStart  = 1'b1;
        tick();
        sampleValid = 1'b0;
        frameStart  = 1'b0;
        nChecks++; if (bufSwapped !== 1'b0) begin nFails++; $display("FAIL same_last_noswap: got %0b want 0", bufSwapped); end
        nChecks++; if (captureBusy !== 1'b0) begin nFails++; $display("FAIL same_full: busy got %0b want 0", captureBusy); end
        readAt(0, rd);
        nChecks++; if (rd !== 8'd200) begin nFails++; $display("FAIL same_old_front: got %0d want 200", rd); end
        pulseFrame();
        nChecks++; if (bufSwapped !== 1'b1) begin nFails++; $display("FAIL same_next_swap: got %0b want 1", bufSwapped); end
        readAt(0, rd);
        nChecks++; if (rd !== 8'd150) begin nFails++; $display("FAIL same_read0: got %0d want 150", rd); end
        readAt(639, rd);
        nChecks++; if (rd !== 8'd21) begin nFails++; $display("FAIL same_read639: got %0d want 21", rd); end
        readAt(700, rd);
        nChecks++; if (rd !== 8'd0) begin nFails++; $display("FAIL same_read700: got %0d want 0", rd); end
        readAt(640, rd);
        nChecks++; if (rd !== 8'd0) begin nFails++; $display("FAIL same_read640: got %0d want 0", rd); end
        readAt(1023, rd);
        nChecks++; if (rd !== 8'd0) begin nFails++; $display("FAIL same_read1023: got %0d want 0", rd); end
    endtask

    task automatic test_reset_mid_capture();
        if (TRIG_MODE) sendSample(8'd10, 0);
        for (int i = 0; i < 200; i++) sendSample(8'(130 + i), 0);
        nChecks++; if (captureBusy !== 1'b1) begin nFails++; $display("FAIL midrst_busy: got %0b want 1", captureBusy); end
        readAt(0, rd);
        nChecks++; if (rd !== 8'd150) begin nFails++; $display("FAIL midrst_front: got %0d want 150", rd); end
        bufRst = 1'b1;
        #2;
        nChecks++; if (curveData !== 8'd0) begin nFails++; $display("FAIL midrst_curve: got %0d want 0", curveData); end
        nChecks++; if (dropCount !== 8'd0) begin nFails++; $display("FAIL midrst_drop: got %0d want 0", dropCount); end
        nChecks++; if (captureBusy !== 1'b1) begin nFails++; $display("FAIL midrst_busy_rst: got %0b want 1", captureBusy); end
        nChecks++; if (bufSwapped !== 1'b0) begin nFails++; $display("FAIL midrst_swapped: got %0b want 0", bufSwapped); end
        @(posedge Clk);
        #1;
        bufRst = 1'b0;
        readAt(0, rd);
        nChecks++; if (rd !== 8'd0) begin nFails++; $display("FAIL midrst_hidden: got %0d want 0", rd); end
        for (int i = 0; i < 640; i++) sendSample(8'(140 + i), 0);
        nChecks++; if (captureBusy !== 1'b0) begin nFails++; $display("FAIL midrst_full: busy got %0b want 0", captureBusy); end
        readAt(0, rd);
        nChecks++; if (rd !== 8'd0) begin nFails++; $display("FAIL midrst_preswap: got %0d want 0", rd); end
        pulseFrame();
        nChecks++; if (bufSwapped !== 1'b1) begin nFails++; $display("FAIL midrst_swap: got %0b want 1", bufSwapped); end
        readAt(0, rd);
        nChecks++; if (rd !== 8'd140) begin nFails++; $display("FAIL midrst_read0: got %0d want 140", rd); end
        readAt(199, rd);
        nChecks++; if (rd !== 8'd83) begin nFails++; $display("FAIL midrst_read199: got %0d want 83", rd); end
        readAt(639, rd);
        nChecks++; if (rd !== 8'd11) begin nFails++; $display("FAIL midrst_read639: got %0d want 11", rd); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_trigger();
        test_timeout();
        test_drop_saturate();
        test_same_cycle();
        test_reset_mid_capture();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
